adc_acq_ctrl: RTL and testbench

Acquisition sequencer for the dual-channel ADC front end. On a start request it discards a configurable number of settling samples from the per-channel millivolt magnitude stream, then accumulates a power-of-two window of samples per channel. It publishes the truncated averages with a one-cycle done pulse. It sits between the ADC voltage-conversion stage and the system control logic that requests measurements.

---
 rtl/adc_acq_pkg.sv | 12 +
 rtl/adc_ch_accum.sv | 33 +++
 rtl/adc_acq_ctrl.sv | 108 ++++++++++
 tb/tb_adc_acq_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// adc_acq_pkg: shared state encoding and width constants for the ADC acquisition sequencer
//   acq_state_t : sequencer states (idle, settle, accumulate, done)
//   CNT_W       : sample counter width, wide enough for SETTLE and 2^AVG_LOG2 - 1
//   acc_w()     : accumulator width DW + AVG_LOG2, so a full window never wraps
package adc_acq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DONE} acq_state_t;
  localparam int CNT_W = 8;
  function automatic int acc_w(input int dw, input int avg_log2);
    return dw + avg_log2;
  endfunction
  localparam int ACC_W = acc_w(16, 4);
endpackage

// File: rtl/adc_ch_accum.sv
// adc_ch_accum: one channel's window accumulator and optional running maximum
//   ad_clk, sys_rst : clock, synchronous active-high reset
//   clear           : zero the accumulator (and peak) at acquisition start
//   add             : accumulate sample this cycle
//   sample          : channel magnitude in mV
//   sum             : running window sum (excludes the sample being added this cycle)
//   peak            : running maximum, present only with ADC_ACQ_PEAK_EN
module adc_ch_accum
  import adc_acq_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = ACC_W
) (
  input  logic          ad_clk,
  input  logic          sys_rst,
  input  logic          clear,
  input  logic          add,
  input  logic [DW-1:0] sample,
  output logic [AW-1:0] sum
`ifdef ADC_ACQ_PEAK_EN
  ,
  output logic [DW-1:0] peak
`endif
);
  always_ff @(posedge ad_clk)
    if (sys_rst || clear) sum <= '0;
    else if (add) sum <= sum + AW'(sample);
`ifdef ADC_ACQ_PEAK_EN
  always_ff @(posedge ad_clk)
    if (sys_rst || clear) peak <= '0;
    else if (add && sample > peak) peak <= sample;
`endif
endmodule

// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: settle-then-average acquisition sequencer for the dual-channel ADC
//   ad_clk, sys_rst      : clock, synchronous active-high reset
//   start, abort         : acquisition request (idle only) / cancel in progress
//   smp_valid            : volt_ch1/volt_ch2 carry a new sample
//   volt_ch1, volt_ch2   : channel magnitudes in mV
//   busy, done           : settling/accumulating flag, one-cycle completion pulse
//   avg_ch1, avg_ch2     : truncated window averages, held until the next done
//   peak_ch1, peak_ch2   : window maxima, present only when ADC_ACQ_PEAK_EN is defined
module adc_acq_ctrl
  import adc_acq_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AVG_LOG2 = 4,
  parameter int SETTLE   = 2
) (
  input  logic          ad_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          abort,
  input  logic          smp_valid,
  input  logic [DW-1:0] volt_ch1,
  input  logic [DW-1:0] volt_ch2,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] avg_ch1,
  output logic [DW-1:0] avg_ch2
`ifdef ADC_ACQ_PEAK_EN
  ,
  output logic [DW-1:0] peak_ch1,
  output logic [DW-1:0] peak_ch2
`endif
);
  localparam int AW = acc_w(DW, AVG_LOG2);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE > 0 ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  acq_state_t state, state_d;
  logic [CNT_W-1:0] cnt;
  logic go, step, add, last;
  logic [AW-1:0] sum1, sum2;
`ifdef ADC_ACQ_PEAK_EN
  logic [DW-1:0] pk1, pk2;
`endif
  always_ff @(posedge ad_clk) state <= sys_rst ? S_IDLE : state_d;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (go) state_d = SETTLE > 0 ? S_SETTLE : S_ACCUM;
      S_SETTLE: state_d = abort ? S_IDLE : (smp_valid && cnt == SET_LAST) ? S_ACCUM : S_SETTLE;
      S_ACCUM:  state_d = abort ? S_IDLE : last ? S_DONE : S_ACCUM;
      default:  state_d = S_IDLE;
    endcase
  end
  // abort masks the final sample, so it beats a simultaneous window completion
  always_comb begin
    busy = state == S_SETTLE || state == S_ACCUM;
    done = state == S_DONE;
    go   = state == S_IDLE && start && !abort;
    step = busy && smp_valid && !abort;
    add  = step && state == S_ACCUM;
    last = add && cnt == WIN_LAST;
  end
  always_ff @(posedge ad_clk)
    if (sys_rst || go) cnt <= '0;
    else if (step) cnt <= (state == S_SETTLE ? cnt == SET_LAST : cnt == WIN_LAST) ? '0 : cnt + 1'b1;
  // the final sample is folded in here rather than in the accumulator
  always_ff @(posedge ad_clk)
    if (sys_rst) begin
      avg_ch1 <= '0;
      avg_ch2 <= '0;
    end else if (last) begin
      avg_ch1 <= DW'((sum1 + AW'(volt_ch1)) >> AVG_LOG2);
      avg_ch2 <= DW'((sum2 + AW'(volt_ch2)) >> AVG_LOG2);
    end
`ifdef ADC_ACQ_PEAK_EN
  always_ff @(posedge ad_clk)
    if (sys_rst) begin
      peak_ch1 <= '0;
      peak_ch2 <= '0;
    end else if (last) begin
      peak_ch1 <= volt_ch1 > pk1 ? volt_ch1 : pk1;
      peak_ch2 <= volt_ch2 > pk2 ? volt_ch2 : pk2;
    end
`endif
  adc_ch_accum #(.DW(DW), .AW(AW)) u_ch1 (
    .ad_clk (ad_clk),
    .sys_rst(sys_rst),
    .clear  (go),
    .add    (add),
    .sample (volt_ch1),
    .sum    (sum1)
`ifdef ADC_ACQ_PEAK_EN
    ,
    .peak   (pk1)
`endif
  );
  adc_ch_accum #(.DW(DW), .AW(AW)) u_ch2 (
    .ad_clk (ad_clk),
    .sys_rst(sys_rst),
    .clear  (go),
    .add    (add),
    .sample (volt_ch2),
    .sum    (sum2)
`ifdef ADC_ACQ_PEAK_EN
    ,
    .peak   (pk2)
`endif
  );
endmodule

// File: tb/tb_adc_acq_ctrl.sv
// tb_adc_acq_ctrl: scoreboard bench for adc_acq_ctrl with default parameters
module tb_adc_acq_ctrl;
  localparam int DW = 16;
  typedef struct {int a1; int a2; int p1; int p2; int dc;} exp_t;
  logic ad_clk = 0, sys_rst = 1, start = 0, abort = 0, smp_valid = 0;
  logic [DW-1:0] volt_ch1 = 0, volt_ch2 = 0;
  logic busy, done;
  logic [DW-1:0] avg_ch1, avg_ch2;
`ifdef ADC_ACQ_PEAK_EN
  logic [DW-1:0] peak_ch1, peak_ch2;
`endif
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int last_a1 = 0, last_a2 = 0, last_p1 = 0, last_p2 = 0;
  adc_acq_ctrl dut (
    .ad_clk   (ad_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .abort    (abort),
    .smp_valid(smp_valid),
    .volt_ch1 (volt_ch1),
    .volt_ch2 (volt_ch2),
    .busy     (busy),
    .done     (done),
    .avg_ch1  (avg_ch1),
    .avg_ch2  (avg_ch2)
`ifdef ADC_ACQ_PEAK_EN
    ,
    .peak_ch1 (peak_ch1),
    .peak_ch2 (peak_ch2)
`endif
  );
  always #5 ad_clk = ~ad_clk;
  always @(posedge ad_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // i < 0 selects a settling sample; i >= 0 is the window sample index
  function automatic int smp(input int mode, input int ch, input int i);
    if (mode == 2) return 65535;
    if (mode == 0) return ch == 1 ? 1000 : 2500;
    if (i < 0) return mode == 1 ? 9999 : 12345;
    if (mode == 1) return ch == 1 ? i : 100 * i + 5;
    return ch == 1 ? 3000 + 7 * i : 40000 - 3 * i;
  endfunction
  always @(negedge ad_clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        check("done_cycle", cyc, e.dc);
        check("avg_ch1", avg_ch1, e.a1);
        check("avg_ch2", avg_ch2, e.a2);
`ifdef ADC_ACQ_PEAK_EN
        check("peak_ch1", peak_ch1, e.p1);
        check("peak_ch2", peak_ch2, e.p2);
`endif
        last_a1 = e.a1;
        last_a2 = e.a2;
        last_p1 = e.p1;
        last_p2 = e.p2;
      end
    end
  end
  // kill: 0 none, 1 abort, 2 sys_rst, applied with the kill_at-th window sample
  task automatic acq(input int mode, input bit gap, input int kill, input int kill_at, input bit restart);
    exp_t e;
    int s1 = 0, s2 = 0;
    bit killed = 0;
    e.p1 = 0;
    e.p2 = 0;
    for (int i = 0; i < 16; i++) begin
      s1 += smp(mode, 1, i);
      s2 += smp(mode, 2, i);
      if (smp(mode, 1, i) > e.p1) e.p1 = smp(mode, 1, i);
      if (smp(mode, 2, i) > e.p2) e.p2 = smp(mode, 2, i);
    end
    e.a1 = s1 >> 4;
    e.a2 = s2 >> 4;
    @(posedge ad_clk); #1;
    start = 1;
    e.dc = cyc + (gap ? 36 : 19);
    if (kill == 0) q.push_back(e);
    @(posedge ad_clk); #1;
    start = 0;
    for (int i = 0; i < 18 && !killed; i++) begin
      check("busy_run", busy, 1);
      smp_valid = 1;
      volt_ch1 = DW'(smp(mode, 1, i - 2));
      volt_ch2 = DW'(smp(mode, 2, i - 2));
      abort = kill == 1 && i - 1 == kill_at;
      sys_rst = kill == 2 && i - 1 == kill_at;
      start = restart && i == 10;
      @(posedge ad_clk); #1;
      {abort, sys_rst, start} = '0;
      if (kill != 0 && i - 1 == kill_at) begin
        killed = 1;
        if (kill == 2) {last_a1, last_a2, last_p1, last_p2} = '0;
        check("kill_busy", busy, 0);
        check("kill_done", done, 0);
        check("kill_avg_ch1", avg_ch1, last_a1);
        check("kill_avg_ch2", avg_ch2, last_a2);
`ifdef ADC_ACQ_PEAK_EN
        check("kill_peak_ch1", peak_ch1, last_p1);
        check("kill_peak_ch2", peak_ch2, last_p2);
`endif
      end else if (gap && i < 17) begin
        smp_valid = 0;
        volt_ch1 = 16'd77;
        volt_ch2 = 16'd88;
        @(posedge ad_clk); #1;
      end
    end
    smp_valid = 0;
    if (killed) return;
    start = restart;
    @(posedge ad_clk); #1;
    start = 0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge ad_clk);
    check("done_seen", q.size(), 0);
    q.delete();
  endtask
  initial begin
    repeat (3) @(posedge ad_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_avg_ch1", avg_ch1, 0);
    check("rst_avg_ch2", avg_ch2, 0);
    sys_rst = 0;
    acq(0, 0, 0, 0, 0);
    acq(1, 0, 0, 0, 0);
    acq(2, 0, 0, 0, 0);
    acq(2, 1, 0, 0, 0);
    acq(3, 0, 0, 0, 0);
    acq(3, 0, 1, 10, 0);
    acq(1, 0, 1, 16, 0);
    acq(0, 0, 0, 0, 1);
    acq(3, 0, 2, 8, 0);
    acq(1, 0, 0, 0, 0);
    repeat (3) @(posedge ad_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
